// File: rtl/pulse_conditioner_if.sv
// Signal bundle between the raw-input source and the pulse conditioner.
// The master drives the raw level and glitch clear; the slave returns the conditioned outputs.
interface pulse_conditioner_if #(
  parameter int GLITCH_W = 8
);
  logic                i_in;
  logic                i_glitch_clr;
  logic                o_pulse;
  logic                o_level;
  logic [GLITCH_W-1:0] o_glitch_count;

  modport master (
    output i_in, i_glitch_clr,
    input  o_pulse, o_level, o_glitch_count
  );

  modport slave (
    input  i_in, i_glitch_clr,
    output o_pulse, o_level, o_glitch_count
  );
endinterface

// File: rtl/pulse_conditioner.sv
// Synchronises a raw input, debounces it over FILTER_CYCLES samples, emits a one-cycle pulse
// per qualified rising edge and keeps a saturating count of rejected glitches.
module pulse_conditioner #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int FILTER_W      = 8,
  parameter int GLITCH_W      = 8
) (
  input  logic clk,
  input  logic rst,
  pulse_conditioner_if.slave bus
);
  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_QUAL = 2'd1,
    HIGH      = 2'd2,
    FALL_QUAL = 2'd3
  } state_t;

  localparam logic [FILTER_W-1:0] C_LAST = FILTER_W'(FILTER_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] C_GMAX = '1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  state_t                 r_state, w_state_nxt;
  logic [FILTER_W-1:0]    r_cnt, w_cnt_nxt;
  logic                   r_level, w_level_nxt;
  logic                   r_pulse, w_pulse_nxt;
  logic                   w_glitch;
  logic [GLITCH_W-1:0]    r_gcnt;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], bus.i_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  // cnt tracks how many consecutive samples have disagreed with the accepted level
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_pulse_nxt = 1'b0;
    w_glitch    = 1'b0;
    case (r_state)
      LOW: begin
        if (w_s) begin
          w_state_nxt = RISE_QUAL;
          w_cnt_nxt   = FILTER_W'(1);
        end
      end
      RISE_QUAL: begin
        if (!w_s) begin
          w_state_nxt = LOW;
          w_cnt_nxt   = '0;
          w_glitch    = 1'b1;
        end else if (r_cnt == C_LAST) begin
          w_state_nxt = HIGH;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b1;
          w_pulse_nxt = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      HIGH: begin
        if (!w_s) begin
          w_state_nxt = FALL_QUAL;
          w_cnt_nxt   = FILTER_W'(1);
        end
      end
      FALL_QUAL: begin
        if (w_s) begin
          w_state_nxt = HIGH;
          w_cnt_nxt   = '0;
          w_glitch    = 1'b1;
        end else if (r_cnt == C_LAST) begin
          w_state_nxt = LOW;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b0;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = LOW;
        w_cnt_nxt   = '0;
        w_level_nxt = 1'b0;
      end
    endcase
  end

  // clear takes priority over a coincident glitch
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_gcnt <= '0;
    else if (bus.i_glitch_clr)              r_gcnt <= '0;
    else if (w_glitch && r_gcnt != C_GMAX)  r_gcnt <= r_gcnt + 1'b1;
  end

  assign bus.o_pulse        = r_pulse;
  assign bus.o_level        = r_level;
  assign bus.o_glitch_count = r_gcnt;
endmodule

// File: doc/pulse_conditioner.md
# pulse_conditioner

Input conditioning stage directly upstream of the frequency counter. Synchronises the raw external signal into the CLK domain and rejects glitches shorter than a programmable number of cycles. Converts each qualified rising edge into a single-cycle PULSE, so the downstream counter increments exactly once per input period regardless of duty cycle. Also keeps a saturating count of rejected glitches for debug.

## Interface
- SYNC_STAGES, 2: synchroniser depth; legal ≥ 2.
- FILTER_CYCLES, 4: consecutive identical synchronised samples required to accept a level change; legal 2 … 2^FILTER_W − 1.
- FILTER_W, 8: width of the qualification counter.
- GLITCH_W, 8: width of GLITCH_COUNT.
- CLK  input  1  system clock (100 MHz); all logic on posedge.
- RESET  input  1  asynchronous, active-high reset; one clock domain only.
- IN  input  1  raw asynchronous external signal.
- GLITCH_CLR  input  1  synchronous clear of GLITCH_COUNT.
- PULSE  output  1  registered; high for exactly one cycle per qualified rising edge.
- LEVEL  output  1  registered filtered level of IN.
- GLITCH_COUNT  output  GLITCH_W  registered saturating count of rejected glitches.

## Operation
- Synchroniser: IN shifts through SYNC_STAGES flops, all reset to 0. s = last stage; the FSM only ever samples s.
- FSM states: LOW, RISE_QUAL, HIGH, FALL_QUAL. Qualification counter cnt (FILTER_W bits).
- LOW: s=1 → RISE_QUAL, cnt←1. Otherwise hold.
- RISE_QUAL:
  - s=0 → LOW, cnt←0, glitch increment.
  - s=1 and cnt=FILTER_CYCLES−1 → HIGH, LEVEL←1, PULSE←1, cnt←0.
  - otherwise cnt←cnt+1.
- HIGH: s=0 → FALL_QUAL, cnt←1. Otherwise hold.
- FALL_QUAL:
  - s=1 → HIGH, cnt←0, glitch increment.
  - s=0 and cnt=FILTER_CYCLES−1 → LOW, LEVEL←0, cnt←0. No pulse on the falling edge.
  - otherwise cnt←cnt+1.
- PULSE is cleared on every edge on which it is not set, giving a one-cycle width.
- GLITCH_COUNT:
  - Increments by 1 on a glitch increment.
  - Saturates at 2^GLITCH_W − 1; no wrap.
  - GLITCH_CLR=1 forces 0. Clear wins over a simultaneous increment.
- Unreachable state encodings recover to LOW with LEVEL=0 and PULSE=0.

## Timing
- Reset values: PULSE=0, LEVEL=0, GLITCH_COUNT=0, state=LOW, cnt=0, synchroniser flops=0. All apply immediately on RESET assertion, independent of CLK.
- Rise latency: IN first sampled high at edge 0 → LEVEL and PULSE rise after edge SYNC_STAGES+FILTER_CYCLES−1 (edge 5 with defaults). PULSE falls after the following edge.
- Fall latency: IN first sampled low at edge 0 → LEVEL falls after edge SYNC_STAGES+FILTER_CYCLES−1.
- Rejection: a high or low excursion of fewer than FILTER_CYCLES synchronised samples does not change LEVEL, produces no PULSE, and adds exactly 1 to GLITCH_COUNT.
- Minimum accepted input period: 2·FILTER_CYCLES cycles. At that period, PULSE fires once every 2·FILTER_CYCLES cycles.
- Reset mid-operation: any in-flight qualification is discarded and no PULSE is emitted. If IN is still high at reset release, a fresh rise qualification runs and exactly one PULSE appears SYNC_STAGES+FILTER_CYCLES−1 edges after the first post-release edge.
- Maximum countable rate downstream: 100 MHz / (2·FILTER_CYCLES).

## Test plan
- Reset with IN=0, then hold 20 cycles → PULSE=0, LEVEL=0, GLITCH_COUNT=0 throughout.
- Defaults; IN low→high held 10 cycles, first sampled at edge 0 → PULSE=1 only in the cycle after edge 5; LEVEL=1 from edge 5 on; GLITCH_COUNT=0.
- Defaults; 3-cycle high blip on IN while LOW → no PULSE, LEVEL stays 0, GLITCH_COUNT=1. A 3-cycle low dip while HIGH → LEVEL stays 1, GLITCH_COUNT=2.
- Defaults; square wave 8 cycles high / 8 low for 100 periods → exactly 100 PULSEs, spaced 16 cycles apart, each 1 cycle wide; GLITCH_COUNT=0.
- GLITCH_W=2: inject 5 glitches → GLITCH_COUNT sticks at 3. Assert GLITCH_CLR on the same edge as a 6th glitch → GLITCH_COUNT=0.
- Assert RESET asynchronously in RISE_QUAL (cnt=2) with IN held high → outputs 0 with no clock edge. After release, exactly one PULSE at edge 5 relative to the first post-release edge.
